// File: rtl/mc_lane_accumulator_if.sv
// Sample-lane and result bundle for mc_lane_accumulator; master drives run control and samples,
// slave publishes status and merged results.
interface mc_lane_accumulator_if #(
    parameter int NUM_LANES = 5,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 64,
    parameter int CNT_W     = 32
);
    logic                        start;
    logic                        abort;
    logic                        hold;
    logic [CNT_W-1:0]            target_cnt;
    logic [NUM_LANES-1:0]        lane_valid;
    logic [NUM_LANES*DATA_W-1:0] lane_data;
    logic                        busy;
    logic                        done;
    logic [ACC_W-1:0]            sum_out;
    logic [ACC_W-1:0]            sum_square_out;
    logic [CNT_W-1:0]            sample_cnt;
    logic                        overflow;

    modport master (
        output start, abort, hold, target_cnt, lane_valid, lane_data,
        input  busy, done, sum_out, sum_square_out, sample_cnt, overflow
    );

    modport slave (
        input  start, abort, hold, target_cnt, lane_valid, lane_data,
        output busy, done, sum_out, sum_square_out, sample_cnt, overflow
    );
endinterface

// File: rtl/mc_lane_accumulator.sv
// Per-lane sum / sum-of-squares accumulation up to a sample target, then a sequential lane merge.
// Done pulses NUM_LANES+1 edges after the last accepting edge; no backpressure, excess samples are dropped.
module mc_lane_accumulator #(
    parameter int NUM_LANES = 5,
    parameter int DATA_W    = 16,
    parameter int ACC_W     = 64,
    parameter int CNT_W     = 32
) (
    input  logic                  clk,
    input  logic                  nreset,
    mc_lane_accumulator_if.slave  bus
);
    localparam int               IDX_W    = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_LANES - 1);

    typedef enum logic [1:0] {IDLE, RUN, MERGE, DONE} state_t;

    state_t           state;
    logic [CNT_W-1:0] target_q;
    logic [CNT_W-1:0] sample_cnt_q;
    logic             busy_q;
    logic             done_q;
    logic             overflow_q;
    logic [ACC_W-1:0] sum_q;
    logic [ACC_W-1:0] sq_q;
    logic [ACC_W-1:0] acc_sum [NUM_LANES];
    logic [ACC_W-1:0] acc_sq  [NUM_LANES];
    logic [ACC_W-1:0] merge_sum;
    logic [ACC_W-1:0] merge_sq;
    logic [IDX_W-1:0] merge_idx;

    logic [CNT_W-1:0]     remaining;
    logic [CNT_W-1:0]     take_cnt;
    logic [CNT_W-1:0]     cnt_nxt;
    logic [NUM_LANES-1:0] take;
    logic                 lane_carry;
    logic [DATA_W-1:0]    lane_d       [NUM_LANES];
    logic [ACC_W:0]       lane_sum_ext [NUM_LANES];
    logic [ACC_W:0]       lane_sq_ext  [NUM_LANES];
    logic [ACC_W:0]       merge_sum_ext;
    logic [ACC_W:0]       merge_sq_ext;

    // Lanes claim the remaining budget in ascending index order; the extra top bit is the carry-out.
    always_comb begin
        remaining  = target_q - sample_cnt_q;
        take       = '0;
        take_cnt   = '0;
        lane_carry = 1'b0;
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_d[i]       = bus.lane_data[i*DATA_W +: DATA_W];
            lane_sum_ext[i] = {1'b0, acc_sum[i]} + (ACC_W+1)'(lane_d[i]);
            lane_sq_ext[i]  = {1'b0, acc_sq[i]}
                            + (ACC_W+1)'((2*DATA_W)'(lane_d[i]) * (2*DATA_W)'(lane_d[i]));
            if (bus.lane_valid[i] && (take_cnt < remaining)) begin
                take[i]    = 1'b1;
                take_cnt   = take_cnt + CNT_W'(1);
                lane_carry = lane_carry | lane_sum_ext[i][ACC_W] | lane_sq_ext[i][ACC_W];
            end
        end
        cnt_nxt       = sample_cnt_q + take_cnt;
        merge_sum_ext = {1'b0, merge_sum} + {1'b0, acc_sum[merge_idx]};
        merge_sq_ext  = {1'b0, merge_sq}  + {1'b0, acc_sq[merge_idx]};
    end

    always_ff @(posedge clk) begin
        if (!nreset) begin
            state        <= IDLE;
            target_q     <= '0;
            sample_cnt_q <= '0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            overflow_q   <= 1'b0;
            sum_q        <= '0;
            sq_q         <= '0;
            merge_sum    <= '0;
            merge_sq     <= '0;
            merge_idx    <= '0;
            for (int i = 0; i < NUM_LANES; i++) begin
                acc_sum[i] <= '0;
                acc_sq[i]  <= '0;
            end
        end else begin
            done_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (!bus.abort && bus.start) begin
                        sample_cnt_q <= '0;
                        overflow_q   <= 1'b0;
                        merge_sum    <= '0;
                        merge_sq     <= '0;
                        if (bus.target_cnt != '0) begin
                            target_q <= bus.target_cnt;
                            for (int i = 0; i < NUM_LANES; i++) begin
                                acc_sum[i] <= '0;
                                acc_sq[i]  <= '0;
                            end
                            busy_q <= 1'b1;
                            state  <= RUN;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                RUN: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else if (!bus.hold) begin
                        for (int i = 0; i < NUM_LANES; i++) begin
                            if (take[i]) begin
                                acc_sum[i] <= lane_sum_ext[i][ACC_W-1:0];
                                acc_sq[i]  <= lane_sq_ext[i][ACC_W-1:0];
                            end
                        end
                        sample_cnt_q <= cnt_nxt;
                        if (lane_carry) overflow_q <= 1'b1;
                        if (cnt_nxt == target_q) begin
                            merge_sum <= '0;
                            merge_sq  <= '0;
                            merge_idx <= '0;
                            state     <= MERGE;
                        end
                    end
                end
                MERGE: begin
                    if (bus.abort) begin
                        busy_q <= 1'b0;
                        state  <= IDLE;
                    end else begin
                        merge_sum <= merge_sum_ext[ACC_W-1:0];
                        merge_sq  <= merge_sq_ext[ACC_W-1:0];
                        if (merge_sum_ext[ACC_W] || merge_sq_ext[ACC_W]) overflow_q <= 1'b1;
                        if (merge_idx == LAST_IDX) begin
                            busy_q <= 1'b0;
                            state  <= DONE;
                        end else begin
                            merge_idx <= merge_idx + IDX_W'(1);
                        end
                    end
                end
                DONE: begin
                    sum_q  <= merge_sum;
                    sq_q   <= merge_sq;
                    done_q <= 1'b1;
                    state  <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.busy           = busy_q;
    assign bus.done           = done_q;
    assign bus.sum_out        = sum_q;
    assign bus.sum_square_out = sq_q;
    assign bus.sample_cnt     = sample_cnt_q;
    assign bus.overflow       = overflow_q;
endmodule
